// File: rtl/dec_pkg.sv
// Shared decode definitions for the RV decode stage.
//   - type_t : 23-bit one-hot instruction type, bit 22..0 =
//              JAL, JALR, BEQ, BNE, LD, SD, ADDI, SLTI, XORI, ORI, ANDI,
//              SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, XOR, SRL, SRA, OR, AND
//   - fmt_t  : 5-bit one-hot format {R, I, S, B, J}
//   - opcode and func7 constants, type-group masks, and fmt_of() which maps
//     a type to its format (zero for an all-zero / illegal type).
package dec_pkg;

  typedef logic [22:0] type_t;
  typedef logic [4:0]  fmt_t;

  localparam type_t T_JAL  = 23'd1 << 22;
  localparam type_t T_JALR = 23'd1 << 21;
  localparam type_t T_BEQ  = 23'd1 << 20;
  localparam type_t T_BNE  = 23'd1 << 19;
  localparam type_t T_LD   = 23'd1 << 18;
  localparam type_t T_SD   = 23'd1 << 17;
  localparam type_t T_ADDI = 23'd1 << 16;
  localparam type_t T_SLTI = 23'd1 << 15;
  localparam type_t T_XORI = 23'd1 << 14;
  localparam type_t T_ORI  = 23'd1 << 13;
  localparam type_t T_ANDI = 23'd1 << 12;
  localparam type_t T_SLLI = 23'd1 << 11;
  localparam type_t T_SRLI = 23'd1 << 10;
  localparam type_t T_SRAI = 23'd1 << 9;
  localparam type_t T_ADD  = 23'd1 << 8;
  localparam type_t T_SUB  = 23'd1 << 7;
  localparam type_t T_SLL  = 23'd1 << 6;
  localparam type_t T_SLT  = 23'd1 << 5;
  localparam type_t T_XOR  = 23'd1 << 4;
  localparam type_t T_SRL  = 23'd1 << 3;
  localparam type_t T_SRA  = 23'd1 << 2;
  localparam type_t T_OR   = 23'd1 << 1;
  localparam type_t T_AND  = 23'd1 << 0;

  localparam fmt_t F_R = 5'b10000;
  localparam fmt_t F_I = 5'b01000;
  localparam fmt_t F_S = 5'b00100;
  localparam fmt_t F_B = 5'b00010;
  localparam fmt_t F_J = 5'b00001;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam type_t SHIFT_IMM_TYPES = T_SLLI | T_SRLI | T_SRAI;
  localparam type_t I_TYPES = T_JALR | T_LD | T_ADDI | T_SLTI | T_XORI | T_ORI
                            | T_ANDI | SHIFT_IMM_TYPES;
  localparam type_t B_TYPES = T_BEQ | T_BNE;
  localparam type_t R_TYPES = T_ADD | T_SUB | T_SLL | T_SLT | T_XOR | T_SRL
                            | T_SRA | T_OR | T_AND;

  function automatic fmt_t fmt_of(input type_t t);
    fmt_t f;
    f = '0;
    if ((t & R_TYPES) != '0)      f = F_R;
    else if ((t & I_TYPES) != '0) f = F_I;
    else if ((t & T_SD) != '0)    f = F_S;
    else if ((t & B_TYPES) != '0) f = F_B;
    else if ((t & T_JAL) != '0)   f = F_J;
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and downstream handshake bundle of the decode stage.
//   slave  : the decode stage (takes flush/in_*/out_ready, drives in_ready/out_*)
//   master : the environment around it (fetch + downstream)
interface decode_stage_if
  import dec_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  type_t           out_type;
  fmt_t            out_format;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_type, out_format,
           out_rd, out_rs1, out_rs2, out_imm, out_illegal
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_type, out_format,
           out_rd, out_rs1, out_rs2, out_imm, out_illegal
  );
endinterface

// File: rtl/dec_comb.sv
// Purely combinational RV instruction decoder.
//   instr   : 32-bit instruction word
//   ty      : one-hot instruction type (zero when illegal)
//   fmt     : one-hot format {R,I,S,B,J} (zero when illegal)
//   imm     : sign-extended immediate, zero-extended shamt for shift-immediates,
//             zero for R-type and illegal words
//   illegal : encoding not supported by this core
module dec_comb
  import dec_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]            instr,
  output type_t                  ty,
  output fmt_t                   fmt,
  output logic signed [XLEN-1:0] imm,
  output logic                   illegal
);

  // 64-bit loads/stores only exist on the 64-bit datapath.
  localparam bit HAS_DW = (XLEN == 64);

  logic [6:0] opcode;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       sh_logic;
  logic       sh_arith;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // With XLEN=64 bit 25 belongs to the 6-bit shamt, so only [31:26] qualify
  // the shift; with XLEN=32 the full func7 must match and bit 25 must be 0.
  generate
    if (XLEN == 64) begin : g_sh64
      assign sh_logic = (instr[31:26] == 6'b000000);
      assign sh_arith = (instr[31:26] == 6'b010000);
    end else begin : g_sh32
      assign sh_logic = (f7 == F7_BASE);
      assign sh_arith = (f7 == F7_ALT);
    end
  endgenerate

  always_comb begin
    ty = '0;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OPC_JAL:    ty = T_JAL;
        OPC_JALR:   if (f3 == 3'b000) ty = T_JALR;
        OPC_BRANCH: begin
          case (f3)
            3'b000:  ty = T_BEQ;
            3'b001:  ty = T_BNE;
            default: ty = '0;
          endcase
        end
        OPC_LOAD:   if (f3 == 3'b011 && HAS_DW) ty = T_LD;
        OPC_STORE:  if (f3 == 3'b011 && HAS_DW) ty = T_SD;
        OPC_OP_IMM: begin
          case (f3)
            3'b000:  ty = T_ADDI;
            3'b010:  ty = T_SLTI;
            3'b100:  ty = T_XORI;
            3'b110:  ty = T_ORI;
            3'b111:  ty = T_ANDI;
            3'b001:  if (sh_logic) ty = T_SLLI;
            3'b101:  ty = sh_logic ? T_SRLI : (sh_arith ? T_SRAI : '0);
            default: ty = '0;
          endcase
        end
        OPC_OP: begin
          case (f3)
            3'b000:  ty = (f7 == F7_BASE) ? T_ADD : ((f7 == F7_ALT) ? T_SUB : '0);
            3'b001:  if (f7 == F7_BASE) ty = T_SLL;
            3'b010:  if (f7 == F7_BASE) ty = T_SLT;
            3'b100:  if (f7 == F7_BASE) ty = T_XOR;
            3'b101:  ty = (f7 == F7_BASE) ? T_SRL : ((f7 == F7_ALT) ? T_SRA : '0);
            3'b110:  if (f7 == F7_BASE) ty = T_OR;
            3'b111:  if (f7 == F7_BASE) ty = T_AND;
            default: ty = '0;
          endcase
        end
        default: ty = '0;
      endcase
    end
  end

  assign fmt     = fmt_of(ty);
  assign illegal = (ty == '0);

  always_comb begin
    imm = '0;
    case (fmt)
      F_I: begin
        // For a legal XLEN=32 shift instr[25] is already known to be 0.
        if ((ty & SHIFT_IMM_TYPES) != '0) imm[5:0] = instr[25:20];
        else imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      F_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      F_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                  instr[11:8], 1'b0};
      F_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                  instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV decode stage between fetch and register read.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : decode_stage_if.slave
//              flush            - drop both held entries and this cycle's input
//              in_valid/in_ready/in_instr/in_pc   - fetch handshake
//              out_valid/out_ready/out_*          - decoded entry to downstream
// Storage is a head (output) register plus one skid register, strict FIFO.
// in_ready is the registered inverse of skid occupancy, so it never depends
// combinationally on out_ready.
module decode_stage
  import dec_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic [PC_W-1:0]        pc;
    type_t                  ty;
    fmt_t                   fmt;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic signed [XLEN-1:0] imm;
    logic                   illegal;
  } entry_t;

  // Stage p0: combinational decode of the incoming word
  type_t                  ty_p0;
  fmt_t                   fmt_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic                   ill_p0;
  entry_t                 ent_p0;

  dec_comb #(.XLEN(XLEN)) u_dec (
    .instr   (bus.in_instr),
    .ty      (ty_p0),
    .fmt     (fmt_p0),
    .imm     (imm_p0),
    .illegal (ill_p0)
  );

  always_comb begin
    ent_p0.pc      = bus.in_pc;
    ent_p0.ty      = ty_p0;
    ent_p0.fmt     = fmt_p0;
    ent_p0.rd      = bus.in_instr[11:7];
    ent_p0.rs1     = bus.in_instr[19:15];
    ent_p0.rs2     = bus.in_instr[24:20];
    ent_p0.imm     = imm_p0;
    ent_p0.illegal = ill_p0;
  end

  // Stage p1: head/skid registers
  entry_t head_p1;
  entry_t skid_p1;
  logic   vld_p1;
  logic   skid_vld_p1;
  logic   in_fire;
  logic   head_free;

  assign in_fire   = bus.in_valid && !skid_vld_p1;
  // Head may be overwritten when empty or when it drains this cycle.
  assign head_free = !vld_p1 || bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      head_p1     <= '0;
      skid_p1     <= '0;
    end else if (bus.flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (head_free) begin
      if (skid_vld_p1) begin
        // in_ready is low while skid is full, so nothing new arrives here.
        head_p1     <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= in_fire;
        if (in_fire) head_p1 <= ent_p0;
      end
    end else if (in_fire) begin
      skid_p1     <= ent_p0;
      skid_vld_p1 <= 1'b1;
    end
  end

  assign bus.in_ready    = !skid_vld_p1;
  assign bus.out_valid   = vld_p1;
  assign bus.out_pc      = head_p1.pc;
  assign bus.out_type    = head_p1.ty;
  assign bus.out_format  = head_p1.fmt;
  assign bus.out_rd      = head_p1.rd;
  assign bus.out_rs1     = head_p1.rs1;
  assign bus.out_rs2     = head_p1.rs2;
  assign bus.out_imm     = head_p1.imm;
  assign bus.out_illegal = head_p1.illegal;

endmodule
